// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Latency: 3 cycles (branch/jal/jalr), 4 (R/I-type, store), 5 (load), +1 per memory wait cycle.
// Backpressure: holds mem_req until mem_ready; abandons the access after TIMEOUT_CYCLES (0 = never).
//
// Ports: clk/rst (async active-high); opcode, br_taken, mem_ready in;
//        mem_req/mem_we/addr_sel memory control; ir_write/pc_write/pc_src PC and IR;
//        alu_src_a/alu_src_b/alu_op ALU control; reg_write/result_sel writeback;
//        retire, mem_err pulses; illegal sticky flag.
// Optional feature: define MULTICYCLE_ILLEGAL_TRAP_EN to halt on an unknown opcode
// (HALT is left only through rst); otherwise an unknown opcode retires as a NOP.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] result_sel,
    output logic       retire,
    output logic       mem_err,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t      state, state_nxt;
    logic [31:0] tcnt;
    logic        known_op;
    logic        req_state;
    logic        tmo_hit;

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_OPIMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: known_op = 1'b1;
            default:                    known_op = 1'b0;
        endcase
    end

    // Only FETCH and MEM drive the memory port. Decoded from state rather than
    // mem_req so the timeout path does not loop back through the output block.
    assign req_state = (state == S_FETCH) || (state == S_MEM);

    // The limit is the TIMEOUT_CYCLES-th request cycle without mem_ready;
    // a mem_ready arriving in that same cycle completes normally.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && req_state && !mem_ready &&
                     (tcnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait-cycle counter: cleared on every state change and on a timeout retry
    // (FETCH -> FETCH), so each FETCH or MEM visit starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if ((state_nxt != state) || tmo_hit) begin
            tcnt <= '0;
        end else if (req_state && !mem_ready) begin
            tcnt <= tcnt + 32'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        result_sel = 2'd0;
        retire     = 1'b0;
        mem_err    = 1'b0;
        illegal    = 1'b0;

        // Everything stays quiet while rst is held; the register is already in FETCH.
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd2;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = S_DECODE;
                    end else if (tmo_hit) begin
                        mem_err = 1'b1;
                    end
                end

                S_DECODE: begin
                    // ALUOut <= OldPC + imm, the branch/JAL target.
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    if (known_op) begin
                        state_nxt = S_EXEC;
                    end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                        state_nxt = S_HALT;
`else
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
`endif
                    end
                end

                S_EXEC: begin
                    state_nxt = S_FETCH;
                    case (opcode)
                        OP_RTYPE: begin
                            alu_src_a = 2'd1;
                            alu_op    = 2'b10;
                            state_nxt = S_WB;
                        end
                        OP_OPIMM: begin
                            alu_src_a = 2'd1;
                            alu_src_b = 2'd1;
                            alu_op    = 2'b11;
                            state_nxt = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a = 2'd1;
                            alu_src_b = 2'd1;
                            state_nxt = S_MEM;
                        end
                        OP_BRANCH: begin
                            alu_src_a = 2'd1;
                            alu_op    = 2'b01;
                            pc_src    = 1'b1;
                            pc_write  = br_taken;
                            retire    = 1'b1;
                        end
                        OP_JAL: begin
                            // PC already holds OldPC+4, which is the link value.
                            pc_write   = 1'b1;
                            pc_src     = 1'b1;
                            reg_write  = 1'b1;
                            result_sel = 2'd2;
                            retire     = 1'b1;
                        end
                        OP_JALR: begin
                            alu_src_a  = 2'd1;
                            alu_src_b  = 2'd1;
                            pc_write   = 1'b1;
                            reg_write  = 1'b1;
                            result_sel = 2'd2;
                            retire     = 1'b1;
                        end
                        default: ;
                    endcase
                end

                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (opcode == OP_STORE);
                    if (mem_ready) begin
                        if (opcode == OP_STORE) begin
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_WB;
                        end
                    end else if (tmo_hit) begin
                        mem_err   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end

                S_WB: begin
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    result_sel = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
                    state_nxt  = S_FETCH;
                end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                S_HALT: begin
                    illegal = 1'b1;
                end
`endif

                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_sel;
    logic       reg_write, retire, mem_err, illegal;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       reg_write;
        logic [1:0] rs;
        logic       retire;
        logic       mem_err;
        logic       illegal;
    } out_t;

    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BAD    = 7'b1111111;

    out_t  act;
    out_t  expq[$];
    string nmq[$];
    int    checks = 0;
    int    errors = 0;
    bit    done = 1'b0;

    multicycle_control #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .result_sel(result_sel), .retire(retire),
        .mem_err(mem_err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = '{mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, result_sel, retire, mem_err, illegal};

    // Hand-derived expected output vectors per state.
    function automatic out_t e_fetch(input logic rdy, input logic err);
        out_t o = '0;
        o.mem_req = 1'b1; o.b = 2'd2;
        o.ir_write = rdy; o.pc_write = rdy; o.mem_err = err;
        return o;
    endfunction

    function automatic out_t e_dec(input logic ret);
        out_t o = '0;
        o.a = 2'd2; o.b = 2'd1; o.retire = ret;
        return o;
    endfunction

    function automatic out_t e_exec(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
        out_t o = '0;
        o.a = a; o.b = b; o.op = op;
        return o;
    endfunction

    function automatic out_t e_mem(input logic we, input logic ret, input logic err);
        out_t o = '0;
        o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = we; o.retire = ret; o.mem_err = err;
        return o;
    endfunction

    function automatic out_t e_wb(input logic [1:0] rs);
        out_t o = '0;
        o.reg_write = 1'b1; o.retire = 1'b1; o.rs = rs;
        return o;
    endfunction

    // One stimulus cycle: apply inputs just after the edge and queue what this cycle must show.
    task automatic cyc(input logic r, input logic [6:0] op, input logic rdy, input logic br,
                       input out_t e, input string nm);
        rst = r; opcode = op; mem_ready = rdy; br_taken = br;
        expq.push_back(e);
        nmq.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Fetch carries a junk opcode to show it is ignored there.
    task automatic fetch_dec(input logic [6:0] op, input string nm);
        cyc(1'b0, BAD, 1'b1, 1'b0, e_fetch(1'b1, 1'b0), {nm, " fetch"});
        cyc(1'b0, op,  1'b1, 1'b0, e_dec(1'b0),        {nm, " decode"});
    endtask

    // Monitor: compares every cycle for which an expectation is queued.
    initial begin
        out_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e  = expq.pop_front();
                nm = nmq.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", nm, act, e);
                end
            end
        end
    end

    initial begin
        out_t o;
        @(posedge clk);
        #1;

        // Reset holds all outputs low even though the state is FETCH.
        cyc(1'b1, RTYPE, 1'b1, 1'b1, '0, "reset0");
        cyc(1'b1, RTYPE, 1'b1, 1'b1, '0, "reset1");

        // R-type, zero-wait.
        fetch_dec(RTYPE, "rtype");
        cyc(1'b0, RTYPE, 1'b1, 1'b0, e_exec(2'd1, 2'd0, 2'b10), "rtype exec");
        cyc(1'b0, RTYPE, 1'b1, 1'b0, e_wb(2'd0), "rtype wb");

        // OP-IMM.
        fetch_dec(OPIMM, "opimm");
        cyc(1'b0, OPIMM, 1'b1, 1'b0, e_exec(2'd1, 2'd1, 2'b11), "opimm exec");
        cyc(1'b0, OPIMM, 1'b1, 1'b0, e_wb(2'd0), "opimm wb");

        // Load with three wait cycles; ready lands on the 4th request cycle (the limit).
        fetch_dec(LOAD, "load");
        cyc(1'b0, LOAD, 1'b1, 1'b0, e_exec(2'd1, 2'd1, 2'b00), "load exec");
        for (int i = 0; i < 3; i++) cyc(1'b0, LOAD, 1'b0, 1'b0, e_mem(1'b0, 1'b0, 1'b0), "load mem wait");
        cyc(1'b0, LOAD, 1'b1, 1'b0, e_mem(1'b0, 1'b0, 1'b0), "load mem ready at limit");
        cyc(1'b0, LOAD, 1'b1, 1'b0, e_wb(2'd1), "load wb");

        // Branch not taken, then taken.
        for (int t = 0; t < 2; t++) begin
            fetch_dec(BRANCH, "branch");
            o = e_exec(2'd1, 2'd0, 2'b01);
            o.pc_src = 1'b1; o.pc_write = (t == 1); o.retire = 1'b1;
            cyc(1'b0, BRANCH, 1'b1, (t == 1), o, "branch exec");
        end

        // JAL.
        fetch_dec(JAL, "jal");
        o = '0; o.pc_write = 1'b1; o.pc_src = 1'b1; o.reg_write = 1'b1; o.rs = 2'd2; o.retire = 1'b1;
        cyc(1'b0, JAL, 1'b1, 1'b0, o, "jal exec");

        // JALR.
        fetch_dec(JALR, "jalr");
        o = e_exec(2'd1, 2'd1, 2'b00);
        o.pc_write = 1'b1; o.reg_write = 1'b1; o.rs = 2'd2; o.retire = 1'b1;
        cyc(1'b0, JALR, 1'b1, 1'b0, o, "jalr exec");

        // Store, zero-wait: 4 cycles, retire in MEM.
        fetch_dec(STORE, "store");
        cyc(1'b0, STORE, 1'b1, 1'b0, e_exec(2'd1, 2'd1, 2'b00), "store exec");
        cyc(1'b0, STORE, 1'b1, 1'b0, e_mem(1'b1, 1'b1, 1'b0), "store mem");

        // Fetch timeout: mem_err on the 4th unanswered request, then FETCH re-issues.
        for (int i = 0; i < TMO - 1; i++) cyc(1'b0, RTYPE, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "fetch wait");
        cyc(1'b0, RTYPE, 1'b0, 1'b0, e_fetch(1'b0, 1'b1), "fetch timeout");
        cyc(1'b0, RTYPE, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "fetch retry");
        cyc(1'b0, RTYPE, 1'b1, 1'b0, e_fetch(1'b1, 1'b0), "fetch retry done");
        cyc(1'b0, RTYPE, 1'b1, 1'b0, e_dec(1'b0), "retry decode");
        cyc(1'b0, RTYPE, 1'b1, 1'b0, e_exec(2'd1, 2'd0, 2'b10), "retry exec");
        cyc(1'b0, RTYPE, 1'b1, 1'b0, e_wb(2'd0), "retry wb");

        // MEM timeout on a load: abandoned, no WB, back to FETCH.
        fetch_dec(LOAD, "loadtmo");
        cyc(1'b0, LOAD, 1'b1, 1'b0, e_exec(2'd1, 2'd1, 2'b00), "loadtmo exec");
        for (int i = 0; i < TMO - 1; i++) cyc(1'b0, LOAD, 1'b0, 1'b0, e_mem(1'b0, 1'b0, 1'b0), "loadtmo wait");
        cyc(1'b0, LOAD, 1'b0, 1'b0, e_mem(1'b0, 1'b0, 1'b1), "loadtmo timeout");
        cyc(1'b0, LOAD, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "loadtmo refetch");

        // Reset in the middle of a stalled store MEM.
        cyc(1'b0, STORE, 1'b1, 1'b0, e_fetch(1'b1, 1'b0), "rststore fetch");
        cyc(1'b0, STORE, 1'b1, 1'b0, e_dec(1'b0), "rststore decode");
        cyc(1'b0, STORE, 1'b1, 1'b0, e_exec(2'd1, 2'd1, 2'b00), "rststore exec");
        cyc(1'b0, STORE, 1'b0, 1'b0, e_mem(1'b1, 1'b0, 1'b0), "rststore mem");
        cyc(1'b1, STORE, 1'b0, 1'b0, '0, "rststore reset");
        cyc(1'b0, STORE, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "post-reset fetch");

        // Unknown opcode.
        cyc(1'b0, BAD, 1'b1, 1'b0, e_fetch(1'b1, 1'b0), "bad fetch");
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        cyc(1'b0, BAD, 1'b1, 1'b0, e_dec(1'b0), "bad decode");
        o = '0; o.illegal = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, RTYPE, 1'b1, 1'b1, o, "halt");
        cyc(1'b1, RTYPE, 1'b1, 1'b0, '0, "halt reset");
        cyc(1'b0, RTYPE, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "halt exit fetch");
`else
        cyc(1'b0, BAD, 1'b1, 1'b0, e_dec(1'b1), "bad decode nop");
        cyc(1'b0, BAD, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "bad next fetch");
`endif

        // Drain the scoreboard.
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        #2;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: bench did not complete, required completion before 100000");
            $fatal(1);
        end
    end

endmodule
